// File: rtl/bus_arb_mux_pkg.sv
// Shared constants and types for the system-bus arbiter/mux: bus polarities,
// default widths, the arbiter state encoding and a small pointer helper.
package bus_arb_mux_pkg;

    localparam int   BUS_MST_CNT = 4;
    localparam logic ENABLE_     = 1'b0;
    localparam logic DISABLE_    = 1'b1;
    localparam logic READ        = 1'b1;
    localparam logic WRITE       = 1'b0;
    localparam int   WORD_ADDR_W = 30;
    localparam int   WORD_DATA_W = 32;

    typedef enum logic {
        BUS_ARB_IDLE  = 1'b0,
        BUS_ARB_OWNED = 1'b1
    } bus_arb_state_t;

    // Round-robin successor of a pointer, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_pick.sv
// Combinational round-robin first-one finder: lowest requester at or above
// start, falling back to the lowest requester overall when none is above it.
module bus_rr_pick
    import bus_arb_mux_pkg::*;
#(
    parameter int NUM_MST = BUS_MST_CNT,
    parameter int PTR_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [NUM_MST-1:0] upper;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MST; gi++) begin : g_upper
            assign upper[gi] = req[gi] && (start <= PTR_W'(gi));
        end
    endgenerate

    // Descending scans so the lowest qualifying index is the one left in idx.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (req[i]) idx = PTR_W'(i);
        end
        if (|upper) begin
            for (int i = NUM_MST - 1; i >= 0; i--) begin
                if (upper[i]) idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Round-robin bus master arbiter with hold-time limit and an integrated
// master-to-slave mux driven from the registered owner.
module bus_arb_mux
    import bus_arb_mux_pkg::*;
#(
    parameter int NUM_MST  = BUS_MST_CNT,
    parameter int ADDR_W   = WORD_ADDR_W,
    parameter int DATA_W   = WORD_DATA_W,
    parameter int MAX_HOLD = 16,
    parameter int PTR_W    = $clog2(NUM_MST)
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [NUM_MST-1:0]         m_req_,
    input  logic [NUM_MST*ADDR_W-1:0]  m_addr,
    input  logic [NUM_MST-1:0]         m_as_,
    input  logic [NUM_MST-1:0]         m_rw,
    input  logic [NUM_MST*DATA_W-1:0]  m_wr_data,
    output logic [NUM_MST-1:0]         m_grnt_,
    output logic [ADDR_W-1:0]          s_addr,
    output logic                       s_as_,
    output logic                       s_rw,
    output logic [DATA_W-1:0]          s_wr_data,
    output logic [PTR_W-1:0]           owner,
    output logic                       busy
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);

    bus_arb_state_t     state_reg, state_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [NUM_MST-1:0] grnt_reg, grnt_next;
    logic               busy_reg, busy_next;

    logic [NUM_MST-1:0] req, owner_onehot, others;
    logic [ADDR_W-1:0]  addr_arr [NUM_MST];
    logic [DATA_W-1:0]  data_arr [NUM_MST];
    logic [PTR_W-1:0]   owner_inc;
    logic               idle_found, hand_found;
    logic [PTR_W-1:0]   idle_idx, hand_idx;
    logic               owner_release, owner_strobing, hold_expired, revoke;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MST; gi++) begin : g_chan
            assign req[gi]          = (m_req_[gi] == ENABLE_);
            assign owner_onehot[gi] = (owner_reg == PTR_W'(gi));
            assign addr_arr[gi]     = m_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi]     = m_wr_data[gi*DATA_W +: DATA_W];
        end

        if (MAX_HOLD != 0) begin : g_hold
            localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
            assign hold_expired = (hold_cnt_reg >= HOLD_LAST);
        end else begin : g_no_hold
            assign hold_expired = 1'b0;
        end
    endgenerate

    assign others         = req & ~owner_onehot;
    assign owner_release  = ~|(req & owner_onehot);
    assign owner_strobing = |(~m_as_ & owner_onehot);
    // A strobed transfer is never cut short by the hold limit.
    assign revoke         = hold_expired && (|others) && !owner_strobing;
    assign owner_inc      = PTR_W'(wrap_inc(int'(owner_reg), NUM_MST));

    bus_rr_pick #(.NUM_MST(NUM_MST), .PTR_W(PTR_W)) u_idle_pick (
        .req   (req),
        .start (rr_ptr_reg),
        .found (idle_found),
        .idx   (idle_idx)
    );

    bus_rr_pick #(.NUM_MST(NUM_MST), .PTR_W(PTR_W)) u_hand_pick (
        .req   (others),
        .start (owner_inc),
        .found (hand_found),
        .idx   (hand_idx)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg    <= BUS_ARB_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            grnt_reg     <= '1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            grnt_reg     <= grnt_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        grnt_next     = grnt_reg;
        busy_next     = busy_reg;
        case (state_reg)
            BUS_ARB_IDLE: begin
                if (idle_found) begin
                    state_next    = BUS_ARB_OWNED;
                    owner_next    = idle_idx;
                    busy_next     = 1'b1;
                    grnt_next     = ~(NUM_MST'(1) << idle_idx);
                    hold_cnt_next = '0;
                end
            end
            BUS_ARB_OWNED: begin
                if (owner_release || revoke) begin
                    rr_ptr_next = owner_inc;
                    if (hand_found) begin
                        owner_next    = hand_idx;
                        grnt_next     = ~(NUM_MST'(1) << hand_idx);
                        hold_cnt_next = '0;
                    end else begin
                        state_next = BUS_ARB_IDLE;
                        busy_next  = 1'b0;
                        grnt_next  = '1;
                    end
                end else if (hold_cnt_reg != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
        endcase
    end

    assign m_grnt_   = grnt_reg;
    assign owner     = owner_reg;
    assign busy      = busy_reg;
    assign s_addr    = busy_reg ? addr_arr[owner_reg] : '0;
    assign s_as_     = busy_reg ? m_as_[owner_reg]    : DISABLE_;
    assign s_rw      = busy_reg ? m_rw[owner_reg]     : READ;
    assign s_wr_data = busy_reg ? data_arr[owner_reg] : '0;

    grant_onehot_a: assert property (@(posedge clk) disable iff (!reset_) $onehot0(~m_grnt_));

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: one instance with MAX_HOLD=4, one with the
// hold limit disabled, both fed the same master-side stimulus.
module tb_bus_arb_mux;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int PW = 2;

    logic            clk;
    logic            reset_;
    logic [N-1:0]    m_req_;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_as_;
    logic [N-1:0]    m_rw;
    logic [N*DW-1:0] m_wr_data;

    logic [N-1:0]  grnt_h, grnt_n;
    logic [AW-1:0] s_addr_h, s_addr_n;
    logic          s_as_h, s_as_n, s_rw_h, s_rw_n;
    logic [DW-1:0] s_wr_data_h, s_wr_data_n;
    logic [PW-1:0] owner_h, owner_n;
    logic          busy_h, busy_n;

    int compared   = 0;
    int mismatched = 0;

    bus_arb_mux #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut_h (
        .clk(clk), .reset_(reset_), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt_(grnt_h), .s_addr(s_addr_h),
        .s_as_(s_as_h), .s_rw(s_rw_h), .s_wr_data(s_wr_data_h), .owner(owner_h), .busy(busy_h)
    );

    bus_arb_mux #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) dut_n (
        .clk(clk), .reset_(reset_), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt_(grnt_n), .s_addr(s_addr_n),
        .s_as_(s_as_n), .s_rw(s_rw_n), .s_wr_data(s_wr_data_n), .owner(owner_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_req_ = '1;
        m_as_  = '1;
        reset_ = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_) begin
            check("onehot_h", 64'($countones(~grnt_h) <= 1), 64'd1);
            check("onehot_n", 64'($countones(~grnt_n) <= 1), 64'd1);
        end
    end

    initial begin
        int order [5];
        logic [N-1:0] exp_g;
        order = '{0, 1, 2, 3, 0};
        reset_ = 1'b0;
        m_req_ = '1;
        m_as_  = '1;
        m_rw   = 4'b0100;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]    = AW'(32'h100 + i);
            m_wr_data[i*DW +: DW] = 32'hD000 + i;
        end
        do_reset();

        // Reset state
        check("rst_grnt", grnt_h, 4'b1111);
        check("rst_busy", busy_h, 0);
        check("rst_owner", owner_h, 0);
        check("rst_saddr", s_addr_h, 0);
        check("rst_sas", s_as_h, 1);
        check("rst_srw", s_rw_h, 1);
        check("rst_swd", s_wr_data_h, 0);

        // Single master 2
        m_req_ = 4'b1011;
        m_as_  = 4'b1011;
        tick();
        check("m2_grnt", grnt_h, 4'b1011);
        check("m2_busy", busy_h, 1);
        check("m2_owner", owner_h, 2);
        check("m2_saddr", s_addr_h, 30'h102);
        check("m2_sas", s_as_h, 0);
        check("m2_srw", s_rw_h, 1);
        check("m2_swd", s_wr_data_h, 32'hD002);
        tick();
        check("m2_hold_grnt", grnt_h, 4'b1011);
        m_req_ = 4'b1111;
        m_as_  = 4'b1111;
        tick();
        check("m2_rel_grnt", grnt_h, 4'b1111);
        check("m2_rel_busy", busy_h, 0);
        check("m2_rel_saddr", s_addr_h, 0);

        // All four request, no hold limit, each holds 3 cycles
        do_reset();
        m_req_ = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = ~(4'b0001 << order[k]);
            check($sformatf("rr%0d_owner", k), owner_n, 64'(order[k]));
            check($sformatf("rr%0d_grnt", k), grnt_n, exp_g);
            check($sformatf("rr%0d_busy", k), busy_n, 1);
            tick();
            check($sformatf("rr%0d_c2", k), owner_n, 64'(order[k]));
            tick();
            check($sformatf("rr%0d_c3", k), owner_n, 64'(order[k]));
            if (k < 4) begin
                m_req_[order[k]] = 1'b1;
                tick();
                check($sformatf("rr%0d_nogap", k), busy_n, 1);
                m_req_[order[k]] = 1'b0;
            end
        end

        // Hold limit revoke
        do_reset();
        m_req_ = 4'b1101;
        tick();
        check("hl_owner1", owner_h, 1);
        m_req_[3] = 1'b0;
        tick();
        tick();
        tick();
        check("hl_c4_owner", owner_h, 1);
        tick();
        check("hl_rev_owner", owner_h, 3);
        check("hl_rev_grnt", grnt_h, 4'b0111);

        // Hold limit deferred by strobe
        do_reset();
        m_req_ = 4'b1101;
        tick();
        m_req_[3] = 1'b0;
        tick();
        tick();
        tick();
        check("hs_c4_owner", owner_h, 1);
        m_as_[1] = 1'b0;
        tick();
        check("hs_c5_owner", owner_h, 1);
        check("hs_c5_sas", s_as_h, 0);
        tick();
        check("hs_c6_owner", owner_h, 1);
        m_as_[1] = 1'b1;
        tick();
        check("hs_rev_owner", owner_h, 3);
        check("hs_rev_grnt", grnt_h, 4'b0111);

        // Pointer wrap
        do_reset();
        m_req_ = 4'b0111;
        tick();
        check("wr_owner3", owner_h, 3);
        m_req_ = 4'b1010;
        tick();
        check("wr_owner0", owner_h, 0);
        check("wr_grnt0", grnt_h, 4'b1110);
        m_req_ = 4'b1011;
        tick();
        check("wr_owner2", owner_h, 2);

        // Asynchronous reset mid-ownership
        do_reset();
        m_req_ = 4'b1101;
        m_as_  = 4'b1101;
        m_rw   = 4'b0100;
        tick();
        check("ar_owner", owner_h, 1);
        check("ar_srw", s_rw_h, 0);
        check("ar_saddr", s_addr_h, 30'h101);
        #3;
        reset_ = 1'b0;
        #1;
        check("ar_grnt", grnt_h, 4'b1111);
        check("ar_busy", busy_h, 0);
        check("ar_sas", s_as_h, 1);
        check("ar_saddr0", s_addr_h, 0);
        check("ar_swd", s_wr_data_h, 0);
        m_req_ = '1;
        m_as_  = '1;
        tick();
        reset_ = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
Parametrised bus master arbiter with an integrated master-to-slave multiplexer for the shared system bus. It takes N request/address/control/data channels and grants the bus to one master at a time with round-robin fairness. An optional hold-time limit stops any one master from monopolising the bus. It drives the shared slave-side address, strobe, rw and write-data lines from the current owner. It replaces fixed-priority muxing that sits behind an external arbiter.

Parameters:
NUM_MST, 4, number of masters (2..16)
ADDR_W, 30, word-address width
DATA_W, 32, word-data width
MAX_HOLD, 16, maximum ownership cycles while others wait; 0 disables the limit
PTR_W, $clog2(NUM_MST), width of the round-robin pointer and owner index (derived)

Ports:
clk  in  1  system clock
reset_  in  1  asynchronous active-low reset
m_req_  in  NUM_MST  per-master bus request, active-low
m_addr  in  NUM_MST*ADDR_W  packed master addresses; master i occupies [i*ADDR_W +: ADDR_W]
m_as_  in  NUM_MST  per-master address strobe, active-low
m_rw  in  NUM_MST  per-master read(1)/write(0)
m_wr_data  in  NUM_MST*DATA_W  packed master write data
m_grnt_  out  NUM_MST  per-master grant, active-low, registered, at most one low
s_addr  out  ADDR_W  shared bus address
s_as_  out  1  shared address strobe, active-low
s_rw  out  1  shared read/write
s_wr_data  out  DATA_W  shared write data
owner  out  PTR_W  index of current owner; valid only while busy=1
busy  out  1  1 while some master holds a grant

Behaviour:
- Reset (asynchronous, reset_=0): m_grnt_ all 1, busy=0, owner=0, rr pointer=0, hold counter=0. Slave side idle: s_addr=0, s_as_=1, s_rw=READ(1), s_wr_data=0.
- FSM states: IDLE and OWNED.
- IDLE: when any m_req_ is low, pick the first requester scanning from the rr pointer upward, mod NUM_MST. Its m_grnt_ goes low on the next clk edge; busy=1; owner=index; go to OWNED. Latency is request to grant = 1 cycle.
- OWNED, owner releases (m_req_[owner]=1):
  - Re-arbitrate in the same cycle among the other requesters, scanning from owner+1.
  - If a requester is found, grant it at the next edge. No idle cycle is inserted.
  - If none is found, drop the grant, busy=0, return to IDLE.
  - rr pointer becomes owner+1 mod NUM_MST. Wrap from NUM_MST-1 goes to 0.
- Hold limit: the hold counter counts cycles in OWNED and resets to 0 on each new grant. The grant is revoked when all of the following hold:
  - MAX_HOLD!=0
  - counter>=MAX_HOLD-1
  - another master is requesting
  - m_as_[owner]=1, so a strobed transfer is never cut
  - On revoke, handover to the next requester happens exactly as on release, and the revoked master may re-request. The counter saturates, never wraps.
- Slave-side mux is combinational from the registered owner/busy:
  - busy=1: s_* = owner channel.
  - busy=0: s_* = idle values as at reset.
- Simultaneous requests: the rr order decides; this is the only tie-break.
- A request that is withdrawn before it is granted is ignored; no grant is remembered.
- Reset asserted mid-transfer: all grants drop immediately (asynchronously) and the bus returns to idle values.
- Only one m_grnt_ may be low in any cycle; this is an invariant, checked by assertion.

Decomposition:
- bus.vh carries: BUS_MST_CNT default, ENABLE_/DISABLE_, READ/WRITE, WordAddr/WordData widths, and the FSM state encodings BUS_ARB_IDLE/BUS_ARB_OWNED.
- One sub-module, bus_rr_pick: a combinational round-robin first-one finder. Inputs are a request vector and a start pointer; outputs are found and index. It is reused for both the IDLE and handover decisions.

Test Plan:
- Single master 2 holds m_req_=0 from cycle 0 -> m_grnt_=4'b1011 at cycle 1; s_addr=m2 address while held; release -> all 1 the next cycle, busy=0.
- All four request continuously with MAX_HOLD=0, each releasing after 3 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
- MAX_HOLD=4, master 1 holds with m_as_=1 while master 3 requests -> master 1 revoked after 4 owned cycles, master 3 granted on the next edge.
- Same as above but m_as_[1]=0 at cycle 4 -> no revoke until the strobe returns to 1.
- Pointer wrap: owner 3 releases while masters 0 and 2 request -> master 0 granted.
- reset_ pulsed low mid-ownership -> m_grnt_=4'b1111, s_as_=1, s_addr=0 immediately, without waiting for clk.
